// File: rtl/przesuniecie_arbiter.sv
// Shift unit (A >>> ~B with error/overflow flags) and a two-port round-robin
// arbiter that shares it behind registered valid/ready handshakes.

module przesuniecie #(
    parameter int BITS = 32
) (
    input  logic signed [BITS-1:0] i_A,
    input  logic signed [BITS-1:0] i_B,
    output logic signed [BITS-1:0] o_result,
    output logic                   o_error,
    output logic                   o_overflow
);
    localparam logic signed [BITS-1:0] LP_MAX = BITS'(BITS);

    logic signed [BITS-1:0] w_amt;

    assign w_amt = ~i_B;

    always_comb begin
        o_result   = '0;
        o_error    = 1'b0;
        o_overflow = 1'b0;
        if (w_amt[BITS-1]) begin
            o_error = 1'b1;
        end else if (w_amt > LP_MAX) begin
            o_overflow = 1'b1;
        end else begin
            o_result = i_A >>> w_amt;
        end
    end
endmodule

module przesuniecie_arbiter #(
    parameter int BITS  = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [BITS-1:0]  i_req0_A,
    input  logic [BITS-1:0]  i_req0_B,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [BITS-1:0]  i_req1_A,
    input  logic [BITS-1:0]  i_req1_B,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [BITS-1:0]  o_rsp_result,
    output logic             o_rsp_error,
    output logic             o_rsp_overflow,
    output logic             o_rsp_id,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [BITS-1:0] r_a;
    logic signed [BITS-1:0] r_b;
    logic                   r_id;
    logic                   r_last_grant;
    logic                   w_grant;
    logic                   w_accept;
    logic signed [BITS-1:0] w_res;
    logic                   w_err;
    logic                   w_ovf;
    logic                   r_rsp_valid;
    logic [BITS-1:0]        r_rsp_result;
    logic                   r_rsp_error;
    logic                   r_rsp_overflow;
    logic                   r_rsp_id;
    logic [CNT_W-1:0]       r_err_cnt;
    logic [CNT_W-1:0]       r_ovf_cnt;

    przesuniecie #(.BITS(BITS)) u_shift (
        .i_A        (r_a),
        .i_B        (r_b),
        .o_result   (w_res),
        .o_error    (w_err),
        .o_overflow (w_ovf)
    );

    // Ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_accept     = 1'b0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req0_valid && i_req1_valid) begin
                    w_grant = ~r_last_grant;
                end else begin
                    w_grant = i_req1_valid;
                end
                if ((i_req0_valid || i_req1_valid) && i_rst_n) begin
                    w_accept     = 1'b1;
                    o_req0_ready = ~w_grant;
                    o_req1_ready = w_grant;
                    w_state_nxt  = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_id           <= 1'b0;
            r_last_grant   <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_error    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_id       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a          <= w_grant ? i_req1_A : i_req0_A;
                r_b          <= w_grant ? i_req1_B : i_req0_B;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == EXEC) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_result   <= (w_err || w_ovf) ? '0 : w_res;
                r_rsp_error    <= w_err;
                r_rsp_overflow <= w_ovf;
                r_rsp_id       <= r_id;
            end else if (r_state == RESP && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
        end else if (r_state == EXEC) begin
            if (w_err && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_ovf && r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_error    = r_rsp_error;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_rsp_id       = r_rsp_id;
    assign o_err_cnt      = r_err_cnt;
    assign o_ovf_cnt      = r_ovf_cnt;
endmodule
